// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module : muldiv_unit_pkg
// Brief  : Shared types and helpers for the HI/LO multiply/divide unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// Module : muldiv_unit_if
// Brief  : ALU <-> multiply/divide unit request, HI/LO access and status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    muldiv_op_t       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );

endinterface

`default_nettype wire

// File: rtl/muldiv_unit_neg_abs.sv
// ============================================================================
// Module : neg_abs
// Brief  : Conditional two's complement, y = neg ? -x : x.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module neg_abs #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module : muldiv_unit
// Brief  : Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clock,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    muldiv_state_t      r_state;
    muldiv_state_t      w_next_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_hi;
    logic               r_neg_lo;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_div;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_signed = op_is_signed(bus.op);
    assign w_div    = op_is_div(bus.op);

    neg_abs #(.WIDTH(WIDTH)) u_abs_a (.neg(w_signed & bus.a[WIDTH-1]), .x(bus.a), .y(w_abs_a));
    neg_abs #(.WIDTH(WIDTH)) u_abs_b (.neg(w_signed & bus.b[WIDTH-1]), .x(bus.b), .y(w_abs_b));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_ok    = ~w_div_diff[WIDTH];
    assign w_div_step  = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};

    neg_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(r_neg_hi), .x(r_acc), .y(w_prod_fix));
    neg_abs #(.WIDTH(WIDTH))   u_fix_quo  (.neg(r_neg_hi), .x(r_acc[WIDTH-1:0]), .y(w_quo_fix));
    neg_abs #(.WIDTH(WIDTH))   u_fix_rem  (.neg(r_neg_lo), .x(r_acc[2*WIDTH-1:WIDTH]), .y(w_rem_fix));

    always_comb begin
        w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            w_res_hi = r_div_zero ? {WIDTH{1'b0}} : w_quo_fix;
            w_res_lo = r_div_zero ? {WIDTH{1'b0}} : w_rem_fix;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MD_IDLE: if (bus.start) w_next_state = MD_RUN;
            MD_RUN:  if (r_cnt == c_cnt_last) w_next_state = MD_FIX;
            MD_FIX:  w_next_state = MD_IDLE;
            default: w_next_state = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_div_zero <= 1'b0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (bus.start) begin
                        r_cnt      <= '0;
                        r_is_div   <= w_div;
                        r_neg_hi   <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_lo   <= w_signed & w_div & bus.a[WIDTH-1];
                        r_div_zero <= w_div & (bus.b == {WIDTH{1'b0}});
                        r_acc      <= {{WIDTH{1'b0}}, (w_div ? w_abs_a : w_abs_b)};
                        r_opb      <= w_div ? w_abs_b : w_abs_a;
                    end
                end
                MD_RUN: begin
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                MD_FIX:  r_done <= 1'b1;
                default: r_done <= 1'b0;
            endcase
        end
    end

    // MTHI/MTLO land only while idle; the FIX edge always wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == MD_FIX) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
        end else if (r_state == MD_IDLE) begin
            if (bus.hi_we) r_hi <= bus.wd;
            if (bus.lo_we) r_lo <= bus.wd;
        end
    end

    assign bus.busy = (r_state != MD_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module : tb_muldiv_unit
// Brief  : Self-checking bench for muldiv_unit against an arithmetic model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {q[31:0], r[31:0]};
            end
            default: begin
                if (b == 32'd0) return 64'd0;
                return {a / b, a % b};
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.op    = muldiv_op_t'(op);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clock);
        #1 bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    // Called right after the start edge; counts cycles up to the done pulse.
    task automatic wait_done(output int cycles, output int busy_cnt, output bit seen);
        seen     = 1'b0;
        cycles   = 0;
        busy_cnt = bus.busy ? 1 : 0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                seen   = 1'b1;
                cycles = i;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.op = MD_MULT; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wd = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
        checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL reset hi: got %h want 0", bus.hi); end
        checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL reset lo: got %h want 0", bus.lo); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd2};
        logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'h80000000};
        logic [31:0] bs  [5] = '{32'hFFFFFFFF, 32'd3, 32'd2, 32'd7, 32'hFFFFFFFF};
        logic [63:0] want[5] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB,
                                 64'hFFFFFFFD_FFFFFFFF, 64'h0000000E_00000002,
                                 64'h80000000_00000000};
        int cyc, bcnt; bit seen;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(cyc, bcnt, seen);
            checks++; if (!seen || cyc != 33) begin errors++; $display("FAIL directed%0d latency: got %0d (seen %b) want 33", i, cyc, seen); end
            checks++; if (bcnt != 33) begin errors++; $display("FAIL directed%0d busy cycles: got %0d want 33", i, bcnt); end
            checks++; if ({bus.hi, bus.lo} !== want[i]) begin errors++; $display("FAIL directed%0d result: got %h_%h want %h", i, bus.hi, bus.lo, want[i]); end
        end
    endtask

    task automatic test_divzero_ignore_start();
        int dones = 0, first = 0;
        issue(2'd3, 32'd5, 32'd0);
        for (int i = 1; i <= 80; i++) begin
            @(posedge clock);
            #1;
            if (bus.start) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (first == 0) first = i;
            end
            if (i == 5) begin
                bus.op = MD_MULTU; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1;
            end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL divzero done count: got %0d want 1", dones); end
        checks++; if (first != 33) begin errors++; $display("FAIL divzero latency: got %0d want 33", first); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL divzero result: got %h_%h want 0_0", bus.hi, bus.lo); end
    endtask

    task automatic test_mthi_mtlo();
        int cyc, bcnt; bit seen;
        @(negedge clock); bus.hi_we = 1'b1; bus.wd = 32'h1234;
        @(posedge clock); #1 bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi idle: got %h want 00001234", bus.hi); end
        @(negedge clock); bus.lo_we = 1'b1; bus.wd = 32'hABCD;
        @(posedge clock); #1 bus.lo_we = 1'b0;
        checks++; if (bus.lo !== 32'hABCD || bus.hi !== 32'h1234) begin errors++; $display("FAIL mtlo idle: got %h_%h want 00001234_0000abcd", bus.hi, bus.lo); end
        issue(2'd1, 32'd2, 32'd3);
        repeat (3) @(posedge clock);
        @(negedge clock); bus.lo_we = 1'b1; bus.hi_we = 1'b1; bus.wd = 32'hDEAD;
        @(posedge clock); #1 bus.lo_we = 1'b0; bus.hi_we = 1'b0;
        checks++; if (bus.lo !== 32'hABCD || bus.hi !== 32'h1234) begin errors++; $display("FAIL mt while busy: got %h_%h want 00001234_0000abcd", bus.hi, bus.lo); end
        wait_done(cyc, bcnt, seen);
        checks++; if (!seen || {bus.hi, bus.lo} !== 64'd6) begin errors++; $display("FAIL mt then multu: got %h_%h (seen %b) want 0_6", bus.hi, bus.lo, seen); end
        // MTHI coinciding with a start: the write lands, then the result overwrites it
        @(negedge clock);
        bus.hi_we = 1'b1; bus.wd = 32'h5555;
        bus.op = MD_MULT; bus.a = 32'hFFFFFFFE; bus.b = 32'd4; bus.start = 1'b1;
        @(posedge clock); #1 bus.hi_we = 1'b0; bus.start = 1'b0;
        checks++; if (bus.hi !== 32'h5555) begin errors++; $display("FAIL mthi with start: got %h want 00005555", bus.hi); end
        wait_done(cyc, bcnt, seen);
        checks++; if (!seen || {bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF8) begin errors++; $display("FAIL mthi overwritten: got %h_%h want ffffffff_fffffff8", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt; bit seen;
        issue(2'd3, 32'd1000, 32'd33);
        wait_done(cyc, bcnt, seen);
        checks++; if (!seen || {bus.hi, bus.lo} !== ref_model(2'd3, 32'd1000, 32'd33)) begin errors++; $display("FAIL b2b first: got %h_%h", bus.hi, bus.lo); end
        issue(2'd0, 32'h00010000, 32'hFFFF0000);
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b accept: got done %b busy %b want 0 1", bus.done, bus.busy); end
        wait_done(cyc, bcnt, seen);
        checks++; if (!seen || cyc != 33 || {bus.hi, bus.lo} !== ref_model(2'd0, 32'h00010000, 32'hFFFF0000)) begin errors++; $display("FAIL b2b second: got %h_%h cyc %0d", bus.hi, bus.lo, cyc); end
        @(posedge clock); #1;
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done width: got %b want 0", bus.done); end
    endtask

    task automatic test_reset_mid_run();
        int cyc, bcnt; bit seen;
        @(negedge clock); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wd = 32'h77;
        @(posedge clock); #1 bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        issue(2'd1, 32'h12345678, 32'h9ABCDEF0);
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock); #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midrun reset status: got busy %b done %b want 0 0", bus.busy, bus.done); end
        checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL midrun reset hilo: got %h_%h want 0_0", bus.hi, bus.lo); end
        @(negedge clock); reset = 1'b0;
        issue(2'd2, 32'hFFFFFC00, 32'd9);
        wait_done(cyc, bcnt, seen);
        checks++; if (!seen || cyc != 33 || {bus.hi, bus.lo} !== ref_model(2'd2, 32'hFFFFFC00, 32'd9)) begin errors++; $display("FAIL after reset op: got %h_%h cyc %0d", bus.hi, bus.lo, cyc); end
    endtask

    task automatic test_random();
        int cyc, bcnt; bit seen;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] want;
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: a = 32'($urandom_range(0, 300));
                3: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            want = ref_model(op, a, b);
            issue(op, a, b);
            wait_done(cyc, bcnt, seen);
            checks++; if (!seen || cyc != 33 || {bus.hi, bus.lo} !== want) begin
                errors++;
                $display("FAIL random%0d op%0d a=%h b=%h: got %h_%h cyc %0d want %h", i, op, a, b, bus.hi, bus.lo, cyc, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_divzero_ignore_start();
        test_mthi_mtlo();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
